// File: rtl/gf_pkg.sv
// Shared definitions for the fetch PC sequencer: FSM state encoding,
// redirect-source encoding and default parameter constants.
package gf_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } gf_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_EXC  = 2'd1,
    REDIR_JMP  = 2'd2
  } gf_redir_e;

  localparam int unsigned GF_ADDR_LEN  = 64;
  localparam int unsigned GF_INST_BLEN = 4;
  localparam int unsigned GF_FETCH_W   = 2;
  localparam int unsigned GF_VEC_SHIFT = 3;
  localparam logic [63:0] GF_RST_ADDR  = '0;

endpackage

// File: rtl/gf_pc_seq_if.sv
// Fetch handshake bundle between the PC sequencer and the fetch stage.
//   i_sig_ready  : fetch stage accepts the current PC
//   o_sig_valid  : o_pc is a valid request
//   o_pc         : fetch PC
//   o_fetch_mask : live instruction slots in the group addressed by o_pc
interface gf_pc_seq_if
  import gf_pkg::*;
#(
  parameter int unsigned ADDR_LEN = GF_ADDR_LEN,
  parameter int unsigned FETCH_W  = GF_FETCH_W
);

  logic                i_sig_ready;
  logic                o_sig_valid;
  logic [ADDR_LEN-1:0] o_pc;
  logic [FETCH_W-1:0]  o_fetch_mask;

  modport master (
    input  i_sig_ready,
    output o_sig_valid,
    output o_pc,
    output o_fetch_mask
  );

  modport slave (
    output i_sig_ready,
    input  o_sig_valid,
    input  o_pc,
    input  o_fetch_mask
  );

endinterface

// File: rtl/gf_pc_redirect_arb.sv
// Combinational redirect arbiter for the fetch PC sequencer.
// Picks exception over jump, forms the winning target, flags a
// simultaneous exception/jump and checks target alignment.
//   i_sig_e        : exception redirect request
//   i_sig_recv_jmp : jump redirect request (raw)
//   i_jmp_en       : jumps may win this cycle
//   i_vec_tbl      : vector table base
//   i_e_id         : exception id
//   i_jmp_target   : jump target
//   o_sel          : winning redirect source
//   o_target       : winning target address
//   o_conflict     : exception and jump requested together
//   o_misalign     : winning target is not instruction aligned
module gf_pc_redirect_arb
  import gf_pkg::*;
#(
  parameter int unsigned ADDR_LEN  = GF_ADDR_LEN,
  parameter int unsigned INST_BLEN = GF_INST_BLEN,
  parameter int unsigned VEC_SHIFT = GF_VEC_SHIFT
) (
  input  logic                i_sig_e,
  input  logic                i_sig_recv_jmp,
  input  logic                i_jmp_en,
  input  logic [ADDR_LEN-1:0] i_vec_tbl,
  input  logic [ADDR_LEN-1:0] i_e_id,
  input  logic [ADDR_LEN-1:0] i_jmp_target,
  output gf_redir_e           o_sel,
  output logic [ADDR_LEN-1:0] o_target,
  output logic                o_conflict,
  output logic                o_misalign
);

  localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ADDR_LEN'(INST_BLEN - 1);

  logic [ADDR_LEN-1:0] exc_target;

  assign exc_target = i_vec_tbl + (i_e_id << VEC_SHIFT);
  assign o_conflict = i_sig_e & i_sig_recv_jmp;

  always_comb begin
    o_sel    = REDIR_NONE;
    o_target = i_jmp_target;
    if (i_sig_e) begin
      o_sel    = REDIR_EXC;
      o_target = exc_target;
    end else if (i_sig_recv_jmp && i_jmp_en) begin
      o_sel    = REDIR_JMP;
      o_target = i_jmp_target;
    end
  end

  assign o_misalign = |(o_target & ALIGN_MASK);

endmodule

// File: rtl/gf_pc_seq.sv
// Fetch PC sequencer: BOOT/RUN/HALT FSM producing the fetch PC, with
// exception/jump redirects, halt/resume and a sticky misalign flag.
//   clk, i_sig_rst   : clock, synchronous active-high reset
//   i_vec_tbl/i_e_id : exception vector base and id; i_sig_e requests
//   i_jmp_target     : jump target; i_sig_recv_jmp requests
//   i_sig_halt       : halt request; i_sig_resume : resume request
//   fetch            : fetch handshake (ready in; valid, pc, mask out)
//   o_sig_misalign   : sticky misaligned-redirect flag
//   o_sig_conflict   : one-cycle pulse after exception+jump collision
//   o_state          : FSM state
module gf_pc_seq
  import gf_pkg::*;
#(
  parameter int unsigned         ADDR_LEN  = GF_ADDR_LEN,
  parameter int unsigned         INST_BLEN = GF_INST_BLEN,
  parameter int unsigned         FETCH_W   = GF_FETCH_W,
  parameter int unsigned         VEC_SHIFT = GF_VEC_SHIFT,
  parameter logic [ADDR_LEN-1:0] RST_ADDR  = ADDR_LEN'(GF_RST_ADDR)
) (
  input  logic                clk,
  input  logic                i_sig_rst,
  input  logic [ADDR_LEN-1:0] i_vec_tbl,
  input  logic [ADDR_LEN-1:0] i_e_id,
  input  logic                i_sig_e,
  input  logic [ADDR_LEN-1:0] i_jmp_target,
  input  logic                i_sig_recv_jmp,
  input  logic                i_sig_halt,
  input  logic                i_sig_resume,
  gf_pc_seq_if.master         fetch,
  output logic                o_sig_misalign,
  output logic                o_sig_conflict,
  output logic [1:0]          o_state
);

  localparam int unsigned         GB       = FETCH_W * INST_BLEN;
  localparam int unsigned         IB_SH    = $clog2(INST_BLEN);
  localparam logic [ADDR_LEN-1:0] GB_MASK  = ADDR_LEN'(GB - 1);
  localparam logic [ADDR_LEN-1:0] GB_BYTES = ADDR_LEN'(GB);

  gf_state_e           state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic                mis_q, mis_d;
  logic                conf_q, conf_d;

  gf_redir_e           arb_sel;
  logic [ADDR_LEN-1:0] arb_target;
  logic                arb_conflict;
  logic                arb_misalign;

  logic                fire;
  logic [ADDR_LEN-1:0] seq_pc;
  logic [ADDR_LEN-1:0] slot;

  gf_pc_redirect_arb #(
    .ADDR_LEN  (ADDR_LEN),
    .INST_BLEN (INST_BLEN),
    .VEC_SHIFT (VEC_SHIFT)
  ) u_arb (
    .i_sig_e        (i_sig_e),
    .i_sig_recv_jmp (i_sig_recv_jmp),
    .i_jmp_en       (state_q == RUN),
    .i_vec_tbl      (i_vec_tbl),
    .i_e_id         (i_e_id),
    .i_jmp_target   (i_jmp_target),
    .o_sel          (arb_sel),
    .o_target       (arb_target),
    .o_conflict     (arb_conflict),
    .o_misalign     (arb_misalign)
  );

  assign fire   = (state_q == RUN) && fetch.i_sig_ready;
  assign seq_pc = (pc_q & ~GB_MASK) + GB_BYTES;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    conf_d  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        conf_d = arb_conflict;
        unique case (arb_sel)
          REDIR_EXC: begin
            pc_d = arb_target;
            if (arb_misalign) begin
              state_d = HALT;
              mis_d   = 1'b1;
            end else begin
              mis_d   = 1'b0;
            end
          end
          REDIR_JMP: begin
            pc_d = arb_target;
            if (arb_misalign) begin
              state_d = HALT;
              mis_d   = 1'b1;
            end else if (i_sig_halt) begin
              state_d = HALT;
            end
          end
          default: begin
            if (i_sig_halt)  state_d = HALT;
            else if (fire)   pc_d    = seq_pc;
          end
        endcase
      end
      HALT: begin
        conf_d = arb_conflict;
        // Only exceptions can redirect from HALT (arb has jumps disabled).
        if (arb_sel == REDIR_EXC) begin
          pc_d = arb_target;
          if (arb_misalign) begin
            mis_d   = 1'b1;
          end else begin
            mis_d   = 1'b0;
            state_d = RUN;
          end
        end else if (i_sig_resume && !mis_q) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_sig_rst) begin
      state_q <= BOOT;
      pc_q    <= RST_ADDR;
      mis_q   <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      conf_q  <= conf_d;
    end
  end

  // Slots before the entry offset inside the fetch group are dead.
  assign slot = (pc_q & GB_MASK) >> IB_SH;

  always_comb begin
    fetch.o_fetch_mask = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      fetch.o_fetch_mask[k] = (ADDR_LEN'(k) >= slot);
    end
  end

  assign fetch.o_sig_valid = (state_q == RUN);
  assign fetch.o_pc        = pc_q;
  assign o_sig_misalign    = mis_q;
  assign o_sig_conflict    = conf_q;
  assign o_state           = state_q;

endmodule

// File: doc/gf_pc_seq.md
GF_PC_SEQ -- requirements
Module: gf_pc_seq

Interface
REQ-001 ADDR_LEN, default 64: width of every address.
REQ-002 INST_BLEN, default 4: instruction size in bytes, power of two.
REQ-003 FETCH_W, default 2: instructions per fetch group, power of two, 1..8.
REQ-004 VEC_SHIFT, default 3: left shift applied to the exception id when forming the vector address.
REQ-005 RST_ADDR, default 0: boot PC, aligned to INST_BLEN.
REQ-006 One clock and a synchronous active-high reset: clk (in, 1, rising-edge clock); i_sig_rst (in, 1, synchronous active-high reset).
REQ-007 Exception inputs: i_vec_tbl (in, ADDR_LEN, vector table base); i_e_id (in, ADDR_LEN, exception id); i_sig_e (in, 1, exception redirect request).
REQ-008 Jump inputs: i_jmp_target (in, ADDR_LEN, jump target); i_sig_recv_jmp (in, 1, jump redirect request).
REQ-009 Halt control: i_sig_halt (in, 1, halt request, WFI-type); i_sig_resume (in, 1, resume request).
REQ-010 Fetch handshake: i_sig_ready (in, 1, fetch stage accepts the PC); o_sig_valid (out, 1, o_pc is a valid request); o_pc (out, ADDR_LEN, fetch PC).
REQ-011 o_fetch_mask (out, FETCH_W): live slots in the group addressed by o_pc.
REQ-012 Status outputs: o_sig_misalign (out, 1, sticky misaligned-redirect flag); o_sig_conflict (out, 1, one-cycle pulse when exception and jump arrive together); o_state (out, 2, FSM state).

Function
REQ-013 FSM states: BOOT, RUN, HALT. After reset the FSM is in BOOT for exactly one cycle, then moves to RUN unconditionally.
REQ-014 o_sig_valid SHALL be 1 only in RUN; a fire is o_sig_valid & i_sig_ready.
REQ-015 Define GB = FETCH_W*INST_BLEN. The sequential next PC is (o_pc & ~(GB-1)) + GB, computed modulo 2^ADDR_LEN; wrap from the top group to 0 is legal and silent.
REQ-016 In RUN with no redirect: o_pc advances to the sequential next PC on a fire and holds otherwise.
REQ-017 The exception target is i_vec_tbl + (i_e_id << VEC_SHIFT), truncated to ADDR_LEN bits. The jump target is i_jmp_target.
REQ-018 Redirect priority is reset > exception > jump > halt > sequential.
REQ-019 A redirect loads o_pc with its target on the next edge regardless of i_sig_ready, so the un-accepted current request is dropped.
REQ-020 When i_sig_e and i_sig_recv_jmp are both 1, the exception wins and o_sig_conflict is 1 for exactly the following cycle.
REQ-021 If the winning target mod INST_BLEN != 0: o_pc is loaded with the target, the FSM enters HALT, and o_sig_misalign is set.
REQ-022 o_sig_misalign is cleared only by reset or by an aligned exception redirect.
REQ-023 i_sig_halt in RUN without an exception: the FSM enters HALT.
REQ-024 Halt with a same-cycle jump: o_pc takes the jump target and the FSM enters HALT.
REQ-025 Halt with a same-cycle exception: the exception is taken and the FSM stays in RUN.
REQ-026 HALT: o_pc holds and jumps are ignored.
REQ-027 In HALT, i_sig_resume returns the FSM to RUN when the misalign flag is clear; otherwise it is ignored.
REQ-028 In HALT, an aligned exception loads its target, clears the misalign flag and returns the FSM to RUN; this takes precedence over resume.
REQ-029 Inputs other than reset are ignored in BOOT.
REQ-030 o_fetch_mask bit k = 1 iff k >= (o_pc mod GB)/INST_BLEN; the value is all-ones when FETCH_W = 1.
REQ-031 o_pc and o_fetch_mask are registered or pure functions of registered state; there is no combinational input-to-output path.

Reset
REQ-032 While i_sig_rst is 1 at an edge: o_pc = RST_ADDR, FSM = BOOT, o_sig_valid = 0, o_sig_misalign = 0, o_sig_conflict = 0.
REQ-033 Reset mid-operation overrides any pending redirect, halt or resume in the same cycle.

Structure
REQ-034 Shared package gf_pkg holds the FSM state encoding (BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2) and the default parameter constants.
REQ-035 One combinational sub-module, gf_pc_redirect_arb, computes the exception target, the priority winner, the conflict flag and the misalign check.
REQ-036 The FSM and all registers live in gf_pc_seq.

Verification (ADDR_LEN=64, INST_BLEN=4, FETCH_W=2, VEC_SHIFT=3, RST_ADDR=0x1000)
REQ-037 Reset then ready held 1 -> BOOT for 1 cycle with valid=0; then o_pc = 0x1000, 0x1008, 0x1010 on successive cycles with mask 2'b11.
REQ-038 Jump to 0x2004, ready 1 -> o_pc = 0x2004 with mask 2'b10; next o_pc = 0x2008.
REQ-039 Ready=0 for 3 cycles at o_pc 0x1008 -> o_pc holds 0x1008; a jump to 0x3000 during the stall -> o_pc = 0x3000 on the next cycle.
REQ-040 i_sig_e=1, i_sig_recv_jmp=1, i_vec_tbl=0x8000, i_e_id=5, jump 0x4000 -> o_pc = 0x8028 and o_sig_conflict pulses for 1 cycle.
REQ-041 Jump to 0x2002 -> HALT, o_pc = 0x2002, misalign=1, valid=0; a following resume is ignored; exception with i_e_id=1 -> o_pc = 0x8008, RUN, misalign=0.
REQ-042 Set o_pc near the top (0xFFFF_FFFF_FFFF_FFF8) and fire -> o_pc = 0x0; assert reset while halted -> o_pc = 0x1000 and BOOT.
